// File: rtl/sha3_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha3_seq_pkg
// Description : Shared types and constants for the Keccak-f[1600] round
//               sequencer and its watchdog.
//               lane_t      - one 64-bit Keccak lane
//               state_t     - 25 lanes, index = x + 5*y
//               seq_state_e - sequencer FSM encoding
// Revision    : 1.0 - initial release
// ============================================================================
package sha3_seq_pkg;

    localparam int KECCAK_ROUNDS = 24;
    localparam int NUM_LANES     = 25;

    typedef logic [63:0] lane_t;
    typedef lane_t state_t [NUM_LANES];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage : sha3_seq_pkg
`default_nettype wire

// File: rtl/sha3_round_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : sha3_round_watchdog
// Description : Cycle counter that times one round-datapath transaction.
//               clear   in  restart the count (issue cycle)
//               enable  in  waiting for the datapath result
//               good    in  datapath result strobe
//               count   out cycles spent waiting, including the current one
//               on_time out good arrived while waiting at exactly
//                           ROUND_LATENCY cycles
//               expired out waiting reached ROUND_LATENCY+TIMEOUT_SLACK
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_round_watchdog #(
    parameter int ROUND_LATENCY = 8,
    parameter int TIMEOUT_SLACK = 4,
    parameter int CNT_W         = $clog2(ROUND_LATENCY + TIMEOUT_SLACK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             good,
    output logic [CNT_W-1:0] count,
    output logic             on_time,
    output logic             expired
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(ROUND_LATENCY + TIMEOUT_SLACK);
    localparam logic [CNT_W-1:0] NOMINAL = CNT_W'(ROUND_LATENCY);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count;

    // The register holds completed wait cycles; the exported count already
    // includes the current one, so the first waiting cycle reads 1.
    assign w_count = (enable && (r_count != LIMIT)) ? r_count + CNT_W'(1) : r_count;

    assign count   = w_count;
    assign on_time = enable && good && (w_count == NOMINAL);
    assign expired = enable && (w_count == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || good) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_count;
        end
    end

endmodule : sha3_round_watchdog
`default_nettype wire

// File: rtl/sha3_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sha3_round_sequencer
// Description : Drives one Keccak-f[1600] permutation through an external
//               fixed-latency round datapath, one round at a time.
//               in_valid/in_ready/in_state      - state to permute
//               rnd_sample/rnd_state/rnd_index  - issue to round datapath
//               rnd_good/rnd_result             - round datapath result
//               out_valid/out_ready/out_state   - permuted state
//               busy                            - FSM not idle
//               err_clear/err_timeout/err_latency - sticky protocol errors
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_round_sequencer
    import sha3_seq_pkg::*;
#(
    parameter int ROUNDS        = KECCAK_ROUNDS,
    parameter int ROUND_LATENCY = 8,
    parameter int TIMEOUT_SLACK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  lane_t      in_state   [NUM_LANES],
    output logic       rnd_sample,
    output lane_t      rnd_state  [NUM_LANES],
    output logic [4:0] rnd_index,
    input  logic       rnd_good,
    input  lane_t      rnd_result [NUM_LANES],
    output logic       out_valid,
    input  logic       out_ready,
    output lane_t      out_state  [NUM_LANES],
    output logic       busy,
    input  logic       err_clear,
    output logic       err_timeout,
    output logic       err_latency
);

    localparam int         CNT_W      = $clog2(ROUND_LATENCY + TIMEOUT_SLACK + 1);
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    seq_state_e       r_fsm;
    logic [4:0]       r_round;
    logic [4:0]       r_rnd_index;
    lane_t            r_lanes     [NUM_LANES];
    lane_t            r_rnd_state [NUM_LANES];
    logic             r_out_of_reset;
    logic             r_err_timeout;
    logic             r_err_latency;

    logic             w_accept;
    logic             w_on_time;
    logic             w_expired;
    logic             w_timeout_evt;
    logic             w_latency_evt;
    logic [CNT_W-1:0] w_unused_count;

    sha3_round_watchdog #(
        .ROUND_LATENCY (ROUND_LATENCY),
        .TIMEOUT_SLACK (TIMEOUT_SLACK),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (r_fsm == ISSUE),
        .enable  (r_fsm == WAIT),
        .good    (rnd_good),
        .count   (w_unused_count),
        .on_time (w_on_time),
        .expired (w_expired)
    );

    // in_ready stays low while reset is asserted and rises on the first
    // clock after release; it never depends on in_valid.
    assign in_ready    = r_out_of_reset && (r_fsm == IDLE);
    assign w_accept    = in_valid && in_ready;
    assign rnd_sample  = (r_fsm == ISSUE);
    assign rnd_state   = r_rnd_state;
    assign rnd_index   = r_rnd_index;
    assign out_valid   = (r_fsm == DONE);
    assign out_state   = r_lanes;
    assign busy        = (r_fsm != IDLE);
    assign err_timeout = r_err_timeout;
    assign err_latency = r_err_latency;

    // on_time is only ever true inside WAIT, so any strobe outside WAIT or at
    // the wrong count is a latency error.
    assign w_latency_evt = rnd_good && !w_on_time;
    assign w_timeout_evt = w_expired && !rnd_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm          <= IDLE;
            r_round        <= '0;
            r_rnd_index    <= '0;
            r_out_of_reset <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_latency  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lanes[i]     <= '0;
                r_rnd_state[i] <= '0;
            end
        end else begin
            r_out_of_reset <= 1'b1;

            case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        r_lanes     <= in_state;
                        r_rnd_state <= in_state;
                        r_round     <= '0;
                        r_rnd_index <= '0;
                        r_fsm       <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_fsm <= WAIT;
                end
                WAIT: begin
                    if (rnd_good) begin
                        r_lanes <= rnd_result;
                        if (r_round == LAST_ROUND) begin
                            r_fsm <= DONE;
                        end else begin
                            // The issue copy is refreshed only when a new
                            // round starts so rnd_state holds between issues.
                            r_rnd_state <= rnd_result;
                            r_round     <= r_round + 5'd1;
                            r_rnd_index <= r_round + 5'd1;
                            r_fsm       <= ISSUE;
                        end
                    end else if (w_expired) begin
                        r_fsm <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase

            // New error events win over a simultaneous clear.
            if (w_timeout_evt) begin
                r_err_timeout <= 1'b1;
            end else if (err_clear) begin
                r_err_timeout <= 1'b0;
            end

            if (w_latency_evt) begin
                r_err_latency <= 1'b1;
            end else if (err_clear) begin
                r_err_latency <= 1'b0;
            end
        end
    end

endmodule : sha3_round_sequencer
`default_nettype wire

// File: tb/tb_sha3_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha3_round_sequencer
// Description : Self-checking bench for sha3_round_sequencer with a
//               behavioural round-datapath model and a scoreboard on the
//               output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_round_sequencer;
    import sha3_seq_pkg::*;

    localparam int R = 2;
    localparam int L = 4;
    localparam int S = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         err_clear = 1'b0;
    logic         spur_good = 1'b0;
    logic         dp_good   = 1'b0;
    logic [1599:0] in_flat  = '0;
    logic [1599:0] dp_flat  = '0;

    lane_t        in_state   [NUM_LANES];
    lane_t        rnd_result [NUM_LANES];
    lane_t        rnd_state  [NUM_LANES];
    lane_t        out_state  [NUM_LANES];
    logic         in_ready, rnd_sample, rnd_good, out_valid, busy;
    logic         err_timeout, err_latency;
    logic [4:0]   rnd_index;
    logic [1599:0] out_flat, rs_flat;

    assign rnd_good = dp_good | spur_good;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            in_state[i]          = in_flat[i*64 +: 64];
            rnd_result[i]        = spur_good ? 64'hDEAD_BEEF_0BAD_F00D : dp_flat[i*64 +: 64];
            out_flat[i*64 +: 64] = out_state[i];
            rs_flat[i*64 +: 64]  = rnd_state[i];
        end
    end

    sha3_round_sequencer #(
        .ROUNDS        (R),
        .ROUND_LATENCY (L),
        .TIMEOUT_SLACK (S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_state    (in_state),
        .rnd_sample  (rnd_sample),
        .rnd_state   (rnd_state),
        .rnd_index   (rnd_index),
        .rnd_good    (rnd_good),
        .rnd_result  (rnd_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_state   (out_state),
        .busy        (busy),
        .err_clear   (err_clear),
        .err_timeout (err_timeout),
        .err_latency (err_latency)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [1599:0] sb_q [$];

    // Round function of the modelled datapath. Mode 0: every lane + 1.
    // Mode 1: lane permutation, rotate and an index-dependent constant.
    function automatic logic [1599:0] dp_fn(logic [1599:0] s, int mode, int idx);
        logic [1599:0] r;
        logic [63:0]   v;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mode == 0) begin
                r[i*64 +: 64] = s[i*64 +: 64] + 64'd1;
            end else begin
                v = s[((i + 7) % NUM_LANES)*64 +: 64];
                r[i*64 +: 64] = {v[62:0], v[63]} ^ (64'h9E37_79B9_7F4A_7C15 * 64'(idx + 1)) ^ 64'(i);
            end
        end
        return r;
    endfunction

    // Reference: a permutation is R successive rounds, indices 0..R-1.
    function automatic logic [1599:0] model(logic [1599:0] s, int mode);
        logic [1599:0] t = s;
        for (int r = 0; r < R; r++) t = dp_fn(t, mode, r);
        return t;
    endfunction

    task automatic chk1(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(string name, logic [1599:0] act, logic [1599:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
                    $display("FAIL %s lane %0d: got %h expected %h", name, i,
                             act[i*64 +: 64], exp[i*64 +: 64]);
                    break;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_state();
        for (int i = 0; i < NUM_LANES; i++) in_flat[i*64 +: 64] = {$urandom, $urandom};
    endtask

    // Datapath model
    int dp_mode     = 0;
    int dp_dly      = L;
    int dp_dly_r0   = L;
    bit dp_never    = 1'b0;
    bit dp_rand_dly = 1'b0;

    initial begin
        int            cnt;
        logic [1599:0] pend;
        cnt  = 0;
        pend = '0;
        forever begin
            step();
            if (!rst_n) begin
                cnt     = 0;
                dp_good = 1'b0;
                continue;
            end
            dp_good = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    dp_good = 1'b1;
                    dp_flat = pend;
                end
            end
            if (rnd_sample) begin
                pend = dp_fn(rs_flat, dp_mode, int'(rnd_index));
                if (!dp_never) begin
                    if (dp_rand_dly)         cnt = int'($urandom_range(1, L + 2));
                    else if (rnd_index == 0) cnt = dp_dly_r0;
                    else                     cnt = dp_dly;
                end
            end
        end
    end

    // Scoreboard monitor: compares on every output handshake.
    initial begin
        logic [1599:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got out_valid=1 expected no pending permutation");
                end else begin
                    exp = sb_q.pop_front();
                    chk_state("out_state", out_flat, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [1599:0] all2;
        logic [1599:0] last_exp;
        int            t;
        int            sent;
        bit            hs;

        for (int i = 0; i < NUM_LANES; i++) all2[i*64 +: 64] = 64'd2;

        // Reset state
        step(); step();
        chk1("rst_rnd_sample", rnd_sample, 0);
        chk1("rst_out_valid", out_valid, 0);
        chk1("rst_busy", busy, 0);
        chk1("rst_err_timeout", err_timeout, 0);
        chk1("rst_err_latency", err_latency, 0);
        chk1("rst_in_ready", in_ready, 0);
        chk_state("rst_state_reg", out_flat, '0);
        rst_n = 1'b1;
        step();
        chk1("post_rst_in_ready", in_ready, 1);

        // Nominal run plus output backpressure
        dp_mode = 0;
        in_flat = '0;
        sb_q.push_back(model('0, 0));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            chk1($sformatf("nom_sample_c%0d", k), rnd_sample, (k == 1 || k == 6));
            if (k == 1) chk1("nom_index_r0", rnd_index, 0);
            if (k == 6) chk1("nom_index_r1", rnd_index, 1);
            chk1($sformatf("nom_out_valid_c%0d", k), out_valid, (k >= 11));
            if (k >= 11) begin
                chk1($sformatf("bp_in_ready_c%0d", k), in_ready, 0);
                chk_state($sformatf("bp_out_state_c%0d", k), out_flat, all2);
            end
            chk1($sformatf("nom_errs_c%0d", k), {err_timeout, err_latency}, 0);
            if (k < 21) step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk1("bp_release_out_valid", out_valid, 0);
        chk1("bp_release_in_ready", in_ready, 1);
        chk1("bp_release_busy", busy, 0);

        // Timeout: datapath never answers
        dp_never = 1'b1;
        rand_state();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk1($sformatf("to_busy_c%0d", k), busy, (k <= 9));
            chk1($sformatf("to_err_c%0d", k), err_timeout, (k >= 10));
            chk1($sformatf("to_out_valid_c%0d", k), out_valid, 0);
            step();
        end
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk1("to_cleared", err_timeout, 0);
        dp_never = 1'b0;

        // Early good on round 0
        dp_mode   = 1;
        dp_dly_r0 = 3;
        rand_state();
        last_exp = model(in_flat, 1);
        sb_q.push_back(last_exp);
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (!out_valid && t < 200) begin
            step();
            t++;
        end
        chk1("early_completes", (t < 200), 1);
        chk1("early_err_latency", err_latency, 1);
        step();
        out_ready = 1'b0;
        chk1("early_sb_drained", sb_q.size(), 0);
        chk1("early_idle", busy, 0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk1("early_cleared", err_latency, 0);
        dp_dly_r0 = L;

        // Spurious good while idle
        spur_good = 1'b1;
        step();
        spur_good = 1'b0;
        chk1("spur_err_latency", err_latency, 1);
        chk1("spur_in_ready", in_ready, 1);
        chk_state("spur_state_kept", out_flat, last_exp);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;

        // Reset during round 1 WAIT
        rand_state();
        sb_q.push_back(model(in_flat, 1));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk1("mid_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_sample", rnd_sample, 0);
        chk1("mid_rst_out_valid", out_valid, 0);
        chk1("mid_rst_busy", busy, 0);
        chk1("mid_rst_errs", {err_timeout, err_latency}, 0);
        chk1("mid_rst_index", rnd_index, 0);
        sb_q.delete();
        step(); step();
        rst_n = 1'b1;
        step();
        chk1("mid_post_in_ready", in_ready, 1);

        // Randomized permutations with random datapath latency and backpressure
        dp_rand_dly = 1'b1;
        sent = 0;
        t    = 0;
        while ((sent < 12 || sb_q.size() != 0) && t < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 12 && $urandom_range(0, 1) == 1) begin
                rand_state();
                in_valid = 1'b1;
            end
            hs = in_valid && in_ready;
            if (hs) begin
                sb_q.push_back(model(in_flat, 1));
                sent++;
            end
            step();
            if (hs) in_valid = 1'b0;
            t++;
        end
        out_ready = 1'b0;
        chk1("rand_all_done", (t < 3000), 1);
        chk1("rand_sent", sent, 12);
        chk1("rand_no_timeout", err_timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sha3_round_sequencer
`default_nettype wire
